// File: rtl/decode_regfile_pipe_if.sv
// Decode/writeback stage bus: decode register fields, E/M/W forwarding sources,
// writeback ports, and the decoded IDs and operands returned to execute.
interface decode_regfile_pipe_if #(parameter int WIDTH = 64);
  logic [3:0]       D_icode, D_rA, D_rB;
  logic [WIDTH-1:0] D_valP;
  logic [3:0]       e_dstE;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       M_dstE, M_dstM;
  logic [WIDTH-1:0] M_valE, m_valM;
  logic [3:0]       W_dstE, W_dstM;
  logic [WIDTH-1:0] W_valE, W_valM;
  logic [3:0]       dbg_sel;
  logic [3:0]       d_srcA, d_srcB, d_dstE, d_dstM;
  logic [WIDTH-1:0] d_valA, d_valB;
  logic [WIDTH-1:0] dbg_val;

  modport master (
    output D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM, dbg_sel,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, dbg_val
  );
  modport slave (
    input  D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM, dbg_sel,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, dbg_val
  );
endinterface

// File: rtl/decode_regfile_pipe.sv
// Y86-64 decode/writeback: register ID decode, 15-entry register file written
// from W, and forwarded operands A/B (one forwarding lane per operand).

// One operand lane: valP, then RNONE->0, then forwarding sources in priority
// order (index 0 highest), then the register file value.
module drp_fwd_sel #(
  parameter int         WIDTH = 64,
  parameter int         NFWD  = 5,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic [3:0]                 src,
  input  logic                       use_valp,
  input  logic [WIDTH-1:0]           valp,
  input  logic [NFWD-1:0][3:0]       fwd_dst,
  input  logic [NFWD-1:0][WIDTH-1:0] fwd_val,
  input  logic [WIDTH-1:0]           rf_val,
  output logic [WIDTH-1:0]           val
);
  logic hit;

  always_comb begin
    val = rf_val;
    hit = 1'b0;
    if (use_valp) begin
      val = valp;
      hit = 1'b1;
    end else if (src == RNONE) begin
      val = '0;
      hit = 1'b1;
    end
    // src is known not to be RNONE here, so an RNONE destination never matches
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && fwd_dst[i] == src) begin
        val = fwd_val[i];
        hit = 1'b1;
      end
    end
  end
endmodule

module decode_regfile_pipe #(
  parameter int         WIDTH = 64,
  parameter int         NREG  = 15,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RRSP  = 4'h4
) (
  input logic                clk,
  input logic                rst_n,
  decode_regfile_pipe_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int NFWD      = 5;

  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
                         I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;

  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic [NREG-1:0][WIDTH-1:0]      rf;
  logic [NUM_LANES-1:0][3:0]       lane_src;
  logic [NUM_LANES-1:0]            lane_valp;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_rf, lane_val;
  logic [WIDTH-1:0]                dbg_rd;
  logic [NFWD-1:0][3:0]            fwd_dst;
  logic [NFWD-1:0][WIDTH-1:0]      fwd_val;

  // Register ID decode; illegal icodes fall through to all-RNONE
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      I_RRMOV: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
      I_IRMOV: dst_e = bus.D_rB;
      I_RMMOV: begin src_a = bus.D_rA; src_b = bus.D_rB; end
      I_MRMOV: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
      I_OPQ:   begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
      I_CALL:  begin src_b = RRSP; dst_e = RRSP; end
      I_RET:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      I_PUSH:  begin src_a = bus.D_rA; src_b = RRSP; dst_e = RRSP; end
      I_POP:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = bus.D_rA; end
      default: ;
    endcase
  end

  // Writes: dstM is applied after dstE so popq %rsp keeps the loaded value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (bus.W_dstE == 4'(r)) rf[r] <= bus.W_valE;
        if (bus.W_dstM == 4'(r)) rf[r] <= bus.W_valM;
      end
    end
  end

  // Combinational reads; ID 15 matches no entry and reads as 0
  always_comb begin
    lane_rf = '0;
    dbg_rd  = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (lane_src[l] == 4'(r)) lane_rf[l] = rf[r];
      if (bus.dbg_sel == 4'(r)) dbg_rd = rf[r];
    end
  end

  assign lane_src  = {src_b, src_a};
  assign lane_valp = {1'b0, (bus.D_icode == I_JXX) || (bus.D_icode == I_CALL)};
  assign fwd_dst   = {bus.W_dstE, bus.W_dstM, bus.M_dstE, bus.M_dstM, bus.e_dstE};
  assign fwd_val   = {bus.W_valE, bus.W_valM, bus.M_valE, bus.m_valM, bus.e_valE};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    drp_fwd_sel #(.WIDTH(WIDTH), .NFWD(NFWD), .RNONE(RNONE)) u_fwd (
      .src      (lane_src[l]),
      .use_valp (lane_valp[l]),
      .valp     (bus.D_valP),
      .fwd_dst  (fwd_dst),
      .fwd_val  (fwd_val),
      .rf_val   (lane_rf[l]),
      .val      (lane_val[l])
    );
  end

  assign bus.d_srcA  = src_a;
  assign bus.d_srcB  = src_b;
  assign bus.d_dstE  = dst_e;
  assign bus.d_dstM  = dst_m;
  assign bus.d_valA  = lane_val[0];
  assign bus.d_valB  = lane_val[1];
  assign bus.dbg_val = dbg_rd;
endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Directed and randomized checks of decode_regfile_pipe against a register-array
// reference model with first-match forwarding lists.
module tb_decode_regfile_pipe;
  localparam logic [3:0] RN = 4'hF, RSP = 4'h4;

  logic clk, rst_n;
  int   npass, ntotal;
  logic [63:0] mrf [15];

  decode_regfile_pipe_if #(.WIDTH(64)) bus ();
  decode_regfile_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return RSP;
    return RN;
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return RN;
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return RN;
  endfunction
  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : RN;
  endfunction

  // Operand value: newest producer wins, falling back to the architectural file
  function automatic logic [63:0] m_operand(input logic [3:0] src);
    logic [3:0]  d [5];
    logic [63:0] v [5];
    if (src == RN) return 64'h0;
    d = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    v = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    foreach (d[i]) if (d[i] != RN && d[i] == src) return v[i];
    return mrf[src];
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] ic;
    ic = bus.D_icode;
    chk({tag, ".srcA"}, 64'(bus.d_srcA), 64'(m_srcA(ic, bus.D_rA)));
    chk({tag, ".srcB"}, 64'(bus.d_srcB), 64'(m_srcB(ic, bus.D_rB)));
    chk({tag, ".dstE"}, 64'(bus.d_dstE), 64'(m_dstE(ic, bus.D_rB)));
    chk({tag, ".dstM"}, 64'(bus.d_dstM), 64'(m_dstM(ic, bus.D_rA)));
    chk({tag, ".valA"}, bus.d_valA,
        (ic inside {4'h7, 4'h8}) ? bus.D_valP : m_operand(m_srcA(ic, bus.D_rA)));
    chk({tag, ".valB"}, bus.d_valB, m_operand(m_srcB(ic, bus.D_rB)));
    chk({tag, ".dbg"}, bus.dbg_val, (bus.dbg_sel == RN) ? 64'h0 : mrf[bus.dbg_sel]);
  endtask

  task automatic clear_model();
    foreach (mrf[i]) mrf[i] = 64'h0;
  endtask

  // One clock edge; the model commits W writes only when reset is released
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (bus.W_dstE != RN) mrf[bus.W_dstE] = bus.W_valE;
      if (bus.W_dstM != RN) mrf[bus.W_dstM] = bus.W_valM;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.D_icode = 4'h1; bus.D_rA = RN; bus.D_rB = RN; bus.D_valP = '0;
    bus.e_dstE = RN; bus.e_valE = '0; bus.M_dstE = RN; bus.M_valE = '0;
    bus.M_dstM = RN; bus.m_valM = '0; bus.W_dstE = RN; bus.W_valE = '0;
    bus.W_dstM = RN; bus.W_valM = '0; bus.dbg_sel = 4'h0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int r = 0; r < 15; r++) begin
      bus.dbg_sel = 4'(r);
      #1 chk(tag, bus.dbg_val, 64'h0);
    end
  endtask

  function automatic logic [3:0] rid();
    case ($urandom_range(0, 5))
      0:       return RN;
      1:       return 4'($urandom_range(0, 15));
      default: return 4'($urandom_range(0, 4));
    endcase
  endfunction

  function automatic logic [63:0] rval();
    return {$urandom, $urandom};
  endfunction

  initial begin
    npass = 0; ntotal = 0;
    clk = 1'b0; rst_n = 1'b0;
    clear_model();
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_zero("reset_dbg");

    // Write then read through the file with no forwarding
    bus.W_dstE = 4'd3; bus.W_valE = 64'h1234;
    tick();
    idle();
    bus.D_icode = 4'h6; bus.D_rA = 4'd3; bus.D_rB = 4'd3;
    #1;
    chk("rf_valA", bus.d_valA, 64'h1234);
    chk("rf_valB", bus.d_valB, 64'h1234);
    chk("rf_dstE", 64'(bus.d_dstE), 64'd3);
    chk("rf_srcA", 64'(bus.d_srcA), 64'd3);

    // Forwarding priority E > M > W > file
    idle();
    bus.W_dstE = 4'd2; bus.W_valE = 64'd5;
    tick();
    idle();
    bus.D_icode = 4'h6; bus.D_rA = 4'd2; bus.D_rB = 4'd1;
    bus.e_dstE = 4'd2; bus.e_valE = 64'd7;
    bus.M_dstE = 4'd2; bus.M_valE = 64'd8;
    bus.W_dstE = 4'd2; bus.W_valE = 64'd9;
    #1 chk("fwd_e", bus.d_valA, 64'd7);
    bus.e_dstE = RN;
    #1 chk("fwd_m", bus.d_valA, 64'd8);
    bus.M_dstE = RN;
    #1 chk("fwd_w", bus.d_valA, 64'd9);
    bus.W_dstE = RN;
    #1 chk("fwd_rf", bus.d_valA, 64'd5);
    check_all("fwd_all");

    // popq %rsp style dual write: valM wins in file and in forwarding
    idle();
    bus.W_dstE = 4'd4; bus.W_valE = 64'd100;
    bus.W_dstM = 4'd4; bus.W_valM = 64'd200;
    bus.D_icode = 4'h9;
    #1;
    chk("dual_srcA", 64'(bus.d_srcA), 64'd4);
    chk("dual_fwd", bus.d_valA, 64'd200);
    tick();
    idle();
    bus.dbg_sel = 4'd4;
    #1 chk("dual_rf", bus.dbg_val, 64'd200);

    // call uses valP; irmovq has no source B
    bus.D_icode = 4'h8; bus.D_valP = 64'h40;
    #1;
    chk("call_valA", bus.d_valA, 64'h40);
    chk("call_srcB", 64'(bus.d_srcB), 64'd4);
    chk("call_dstE", 64'(bus.d_dstE), 64'd4);
    chk("call_srcA", 64'(bus.d_srcA), 64'(RN));
    idle();
    bus.D_icode = 4'h3; bus.D_rB = 4'd5;
    #1;
    chk("irmov_dstE", 64'(bus.d_dstE), 64'd5);
    chk("irmov_srcB", 64'(bus.d_srcB), 64'(RN));
    chk("irmov_valB", bus.d_valB, 64'h0);

    // RNONE destinations never write; ID 15 reads 0
    idle();
    bus.W_valE = '1; bus.W_valM = '1;
    repeat (4) tick();
    for (int r = 0; r < 15; r++) begin
      bus.dbg_sel = 4'(r);
      #1 chk("rnone_nowrite", bus.dbg_val, mrf[r]);
    end
    bus.dbg_sel = RN;
    #1 chk("dbg_rnone", bus.dbg_val, 64'h0);

    // Illegal icode yields zero operands even with forwarding sources present
    bus.D_icode = 4'hC; bus.D_rA = 4'd2; bus.D_rB = 4'd2;
    bus.e_dstE = 4'd2; bus.e_valE = 64'd77;
    #1;
    chk("illegal_valA", bus.d_valA, 64'h0);
    chk("illegal_valB", bus.d_valB, 64'h0);

    // Asynchronous reset between edges, and writes blocked while held
    idle();
    rst_n = 1'b0;
    clear_model();
    sweep_zero("async_rst");
    bus.W_dstE = 4'd1; bus.W_valE = 64'hDEAD;
    tick();
    bus.dbg_sel = 4'd1;
    #1 chk("rst_block", bus.dbg_val, 64'h0);
    idle();
    rst_n = 1'b1;

    // Randomized traffic against the model, with occasional reset pulses
    for (int it = 0; it < 300; it++) begin
      bus.D_icode = 4'($urandom_range(0, 15));
      bus.D_rA = rid(); bus.D_rB = rid(); bus.D_valP = rval();
      bus.e_dstE = rid(); bus.e_valE = rval();
      bus.M_dstE = rid(); bus.M_valE = rval();
      bus.M_dstM = rid(); bus.m_valM = rval();
      bus.W_dstE = rid(); bus.W_valE = rval();
      bus.W_dstM = rid(); bus.W_valM = rval();
      bus.dbg_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        clear_model();
      end
      #1 check_all("rand");
      tick();
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
